sigmoid_share_arbiter: RTL and testbench

- Shares one piecewise-linear sigmoid datapath between two requesters: the encoder-side stream (port 0) and the decoder-side stream (port 1) of the VAE.
- The datapath is the gradient_offset segment lookup followed by a multiply-add. It is wrapped in a 3-stage stallable pipeline with round-robin arbitration at the input.
- Results return on one tagged output channel with valid/ready backpressure.

---
 rtl/sigmoid_share_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sigmoid_share_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_share_arbiter.sv
// sigmoid_share_arbiter
// Shares one piecewise-linear sigmoid datapath between two requesters.
// Port 0 is the encoder-side stream and port 1 is the decoder-side stream.
// A round-robin arbiter feeds a 3-stage stallable pipeline:
//   S1 captures the sample, S2 does the segment lookup, S3 does the multiply-add.
// Results leave on one tagged output channel that uses valid/ready.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in0_valid/data/ready requester 0 handshake, sample x in Q8.8
//   in1_valid/data/ready requester 1 handshake, sample x in Q8.8
//   out_valid/data/id    result sigmoid(x) in Q8.8, plus the owning requester
//   out_ready            consumer accepts the result
//   busy                 some pipeline stage holds a valid sample
//   sat_count            saturating count of results taken from a flat segment
//   clr_count            synchronous clear of sat_count
module sigmoid_share_arbiter #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [DW-1:0]    in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [DW-1:0]    in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] sat_count,
  input  logic             clr_count
);

  logic          stall;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          rr_ptr;

  logic          s1_valid;
  logic [DW-1:0] s1_x;
  logic          s1_id;

  logic          s2_valid;
  logic [DW-1:0] s2_x;
  logic          s2_id;
  logic [DW-1:0] s2_grad;
  logic [DW-1:0] s2_off;
  logic          s2_sat;

  logic          s3_valid;
  logic          s3_sat;

  logic          ovf;
  logic [DW-1:0] neg_x;
  logic [10:0]   mag;
  logic [3:0]    seg;
  logic [DW-1:0] lut_grad;
  logic [DW-1:0] lut_off;

  logic signed [2*DW-1:0] prod;
  logic [DW-1:0]          mac;
  logic                   unused_bits;

  // The whole pipeline freezes while the result at the output is not taken,
  // even if upstream stages hold bubbles; this keeps the control trivial.
  assign stall = s3_valid & ~out_ready;

  // Round-robin grant: a lone requester always wins, a tie goes to rr_ptr.
  always_comb begin
    grant0 = in0_valid & (~in1_valid | ~rr_ptr);
    grant1 = in1_valid & (~in0_valid | rr_ptr);
  end

  // Ready is gated by rst so nothing looks accepted while reset is held.
  assign in0_ready = grant0 & ~stall & ~rst;
  assign in1_ready = grant1 & ~stall & ~rst;
  assign accept    = in0_ready | in1_ready;

  // Pointer moves to the other requester after every accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~grant1;
    end
  end

  // S1: capture the granted sample and its owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_id    <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      s1_x     <= grant1 ? in1_data : in0_data;
      s1_id    <= grant1;
    end
  end

  // Segment selection. ovf flags any integer part outside the 3-bit range; the
  // magnitude is taken modulo 2^11, so exactly -8.0 folds onto segment 0.
  always_comb begin
    ovf   = |({(DW-12){s1_x[DW-1]}} ^ s1_x[DW-2:11]);
    neg_x = -s1_x;
    mag   = s1_x[DW-1] ? neg_x[10:0] : s1_x[10:0];
    seg   = ovf ? 4'd8 : {1'b0, mag[10:8]};
  end

  // Gradient/offset table for the positive half; the negative half reuses the
  // same gradients and mirrors the offset around 0.5 using sigmoid(-x)=1-sigmoid(x).
  always_comb begin
    lut_grad = '0;
    lut_off  = 16'h0100;
    case (seg)
      4'd0: begin lut_grad = 16'h003B; lut_off = 16'h0080; end
      4'd1: begin lut_grad = 16'h0026; lut_off = 16'h0093; end
      4'd2: begin lut_grad = 16'h0012; lut_off = 16'h00BD; end
      4'd3: begin lut_grad = 16'h0008; lut_off = 16'h00DD; end
      4'd4: begin lut_grad = 16'h0003; lut_off = 16'h00F0; end
      4'd5: begin lut_grad = 16'h0001; lut_off = 16'h00F9; end
      default: begin lut_grad = 16'h0000; lut_off = 16'h0100; end
    endcase
    if (s1_x[DW-1]) begin
      lut_off = 16'h0100 - lut_off;
    end
  end

  // S2: hold lookup results alongside the sample for the multiply-add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_id    <= 1'b0;
      s2_grad  <= '0;
      s2_off   <= '0;
      s2_sat   <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_x     <= s1_x;
      s2_id    <= s1_id;
      s2_grad  <= lut_grad;
      s2_off   <= lut_off;
      s2_sat   <= (seg >= 4'd6);
    end
  end

  // Q8.8 times Q8.8 gives Q16.16; bits [23:8] bring it back to Q8.8.
  always_comb begin
    prod = $signed(s2_grad) * $signed(s2_x);
    mac  = prod[23:8] + s2_off;
  end

  assign unused_bits = ^{prod[2*DW-1:24], prod[7:0], neg_x[DW-1:11]};

  // S3: the output register; it holds steady whenever the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      out_data <= '0;
      out_id   <= 1'b0;
      s3_sat   <= 1'b0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      out_data <= mac;
      out_id   <= s2_id;
      s3_sat   <= s2_sat;
    end
  end

  assign out_valid = s3_valid;
  assign busy      = s1_valid | s2_valid | s3_valid;

  // Counts saturated results as they are actually handed off; it sticks at
  // all-ones instead of wrapping, and a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (clr_count) begin
      sat_count <= '0;
    end else if (s3_valid && out_ready && s3_sat && (sat_count != {CNT_W{1'b1}})) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// tb_sigmoid_share_arbiter
// Scoreboard bench for sigmoid_share_arbiter. A reference process predicts
// grants and pushes expected results on every accept; a separate monitor pops
// and compares whenever a result is handed off, and tracks sat_count.
module tb_sigmoid_share_arbiter;

  logic        clk;
  logic        rst;
  logic        in0_valid;
  logic [15:0] in0_data;
  logic        in0_ready;
  logic        in1_valid;
  logic [15:0] in1_data;
  logic        in1_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_id;
  logic        out_ready;
  logic        busy;
  logic [15:0] sat_count;
  logic        clr_count;

  typedef struct packed {
    logic [15:0] data;
    logic        id;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  // Reference-model state: occupancy of the three stages and the tie-break owner.
  logic pipe [0:2];
  logic rr_model;

  // Monitor state.
  int          sat_exp;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_id;

  sigmoid_share_arbiter #(.DW(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy),
    .sat_count (sat_count),
    .clr_count (clr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and keep the running tallies.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic v0, input logic [15:0] d0,
                               input logic v1, input logic [15:0] d1,
                               input logic ordy, input logic clr);
    @(posedge clk);
    #1;
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = ordy;
    clr_count = clr;
  endtask

  // Sigmoid computed from the segment rules with plain integer arithmetic.
  function automatic exp_t refCalc(input logic [15:0] x, input logic id);
    int   xi, mag, seg, grad, off, res;
    exp_t e;
    xi  = int'($signed(x));
    mag = (xi < 0) ? -xi : xi;
    if (xi >= 2048 || xi < -2048) seg = 8;
    else                          seg = (mag % 2048) / 256;
    case (seg)
      0:       begin grad = 59; off = 128; end
      1:       begin grad = 38; off = 147; end
      2:       begin grad = 18; off = 189; end
      3:       begin grad = 8;  off = 221; end
      4:       begin grad = 3;  off = 240; end
      5:       begin grad = 1;  off = 249; end
      default: begin grad = 0;  off = 256; end
    endcase
    if (xi < 0) off = 256 - off;
    res    = ((grad * xi) >>> 8) + off;
    e.data = res[15:0];
    e.id   = id;
    e.sat  = (seg >= 6);
    return e;
  endfunction

  // Reference process: predicts grants and occupancy, queues expected results.
  always @(negedge clk) begin
    logic stall_m, g0, g1;
    if (rst) begin
      pipe[0]  = 1'b0;
      pipe[1]  = 1'b0;
      pipe[2]  = 1'b0;
      rr_model = 1'b0;
      exp_q.delete();
    end else begin
      checkOutput("out_valid", out_valid, pipe[2]);
      checkOutput("busy", busy, pipe[0] | pipe[1] | pipe[2]);
      stall_m = pipe[2] && !out_ready;
      g0 = !stall_m && in0_valid && (!in1_valid || rr_model == 1'b0);
      g1 = !stall_m && in1_valid && (!in0_valid || rr_model == 1'b1);
      checkOutput("in0_ready", in0_ready, g0);
      checkOutput("in1_ready", in1_ready, g1);
      if (!stall_m) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = g0 | g1;
        if (g0) begin
          exp_q.push_back(refCalc(in0_data, 1'b0));
          rr_model = 1'b1;
        end else if (g1) begin
          exp_q.push_back(refCalc(in1_data, 1'b1));
          rr_model = 1'b0;
        end
      end
    end
  end

  // Monitor: pops on each handoff, checks stability under stall and sat_count.
  always @(negedge clk) begin
    exp_t e;
    logic xfer_sat;
    if (rst) begin
      sat_exp    = 0;
      prev_stall = 1'b0;
    end else begin
      checkOutput("sat_count_model", sat_count, sat_exp);
      if (prev_stall) begin
        checkOutput("hold_data", out_data, prev_data);
        checkOutput("hold_id", out_id, prev_id);
      end
      xfer_sat = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result_qsize", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_data", out_data, e.data);
          checkOutput("sb_id", out_id, e.id);
          xfer_sat = e.sat;
        end
      end
      if (clr_count)                        sat_exp = 0;
      else if (xfer_sat && sat_exp != 65535) sat_exp++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_id    = out_id;
    end
  end

  // Wait a bounded time for the next result and check value, latency and count.
  task automatic expectOut(input logic [15:0] d, input logic id, input int exp_sat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk);
      n++;
    end
    checkOutput("latency", n, 3);
    checkOutput("dir_data", out_data, d);
    checkOutput("dir_id", out_id, id);
    if (exp_sat >= 0) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("dir_sat_count", sat_count, exp_sat);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [15:0] held_data;
    logic        held_id;
    int          xi;
    logic [15:0] r0, r1;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 16'h0100;
    in1_valid = 1'b1;
    in1_data  = 16'h0200;
    out_ready = 1'b1;
    clr_count = 1'b0;

    // Reset state with requests pending: nothing may look accepted.
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_id", out_id, 0);
    checkOutput("rst_in0_ready", in0_ready, 0);
    checkOutput("rst_in1_ready", in1_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sat_count", sat_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;

    // Directed single requests, including negative and saturated inputs.
    $display("[TB] directed single requests");
    applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0, 1'b1, 1'b0);
    expectOut(16'h0080, 1'b0, 0);
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h0100, 1'b1, 1'b0);
    expectOut(16'h00B9, 1'b1, 0);
    applyStimulus(1'b1, 16'hFF00, 1'b0, 16'h0, 1'b1, 1'b0);
    expectOut(16'h0047, 1'b0, 0);
    applyStimulus(1'b1, 16'h0800, 1'b0, 16'h0, 1'b1, 1'b0);
    expectOut(16'h0100, 1'b0, 1);
    applyStimulus(1'b1, 16'h8000, 1'b0, 16'h0, 1'b1, 1'b0);
    expectOut(16'h0000, 1'b0, 2);
    idleCycles(3);

    // Reset with two samples in flight: everything drops at once.
    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 16'h0123, 1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 16'hFE40, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Both ports every cycle: grants alternate starting at port 0.
    $display("[TB] round robin");
    for (int i = 0; i < 8; i++) begin
      r0 = 16'($urandom_range(0, 4095));
      r1 = 16'($urandom_range(0, 4095));
      applyStimulus(1'b1, r0, 1'b1, r1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("rr_in0_ready", in0_ready, (i % 2 == 0));
      checkOutput("rr_in1_ready", in1_ready, (i % 2 == 1));
    end
    idleCycles(5);

    // Three samples in flight, consumer stalls four cycles, then drains.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 16'h0040, 1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 16'hFD00, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h0333, 1'b0, 16'h0, 1'b1, 1'b0);
    held_data = 16'h0;
    held_id   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h0011, 1'b1, 16'h0022, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("stall_in0_ready", in0_ready, 0);
      checkOutput("stall_in1_ready", in1_ready, 0);
      checkOutput("stall_out_valid", out_valid, 1);
      if (i == 0) begin
        held_data = out_data;
        held_id   = out_id;
        checkOutput("stall_first_id", out_id, 0);
      end else begin
        checkOutput("stall_data_const", out_data, held_data);
        checkOutput("stall_id_const", out_id, held_id);
      end
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("drain_valid", out_valid, 1);
      checkOutput("drain_id", out_id, (i == 1));
    end
    idleCycles(5);

    // Randomized traffic with random backpressure and occasional clears.
    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = 16'($urandom);
      else begin xi = int'($urandom_range(0, 4400)) - 2200; r0 = 16'(xi); end
      if ($urandom_range(0, 3) == 0) r1 = 16'($urandom);
      else begin xi = int'($urandom_range(0, 4400)) - 2200; r1 = 16'(xi); end
      applyStimulus($urandom_range(0, 3) != 0, r0, $urandom_range(0, 3) != 0, r1,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end
    idleCycles(6);

    // Saturation of the event counter, then clear racing an increment.
    $display("[TB] sat_count boundary");
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 65600; i++) begin
      applyStimulus(1'b1, 16'h0800, 1'b1, 16'h8000, 1'b1, 1'b0);
    end
    @(negedge clk);
    checkOutput("sat_max", sat_count, 16'hFFFF);
    applyStimulus(1'b1, 16'h0800, 1'b1, 16'h8000, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("clr_xfer_valid", out_valid, 1);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("sat_clr_priority", sat_count, 0);
    idleCycles(8);
    @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
